key_conditioner: RTL

//  Input-side counterpart to the display path. Conditions the raw active-low board

---
 rtl/key_conditioner_pkg.sv | 13 +
 rtl/key_debounce_channel.sv | 82 ++++++++
 rtl/key_conditioner.sv | 58 +++++
 3 files changed

// File: rtl/key_conditioner_pkg.sv
// rtl/key_conditioner_pkg.sv - shared constants and helpers for the key conditioning path
package key_conditioner_pkg;

   // Board pushbuttons pull low when pressed
   localparam logic KEY_ACTIVE     = 1'b0;
   localparam int   CLK_HZ_DEFAULT = 50_000_000;

   // Convert a millisecond interval into clock cycles
   function automatic int ms_to_cycles(input int clk_hz, input int ms);
      return clk_hz / 1000 * ms;
   endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// rtl/key_debounce_channel.sv - one key: synchroniser, debouncer, hold timer and event pulses
module key_debounce_channel
   import key_conditioner_pkg::*;
#(
   parameter int DB_CYCLES   = 8,
   parameter int HOLD_CYCLES = 32
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic key_level,
   output logic key_press,
   output logic key_release,
   output logic key_hold,
   output logic press_set
);

   localparam int DBW = $clog2(DB_CYCLES + 1);
   localparam int HW  = $clog2(HOLD_CYCLES + 1);

   logic          sync1;
   logic          sync2;
   logic [DBW-1:0] db_cnt;
   logic [HW-1:0]  hold_cnt;
   logic          sample;
   logic          accept;

   assign sample = (sync2 == KEY_ACTIVE);
   // The disagreeing sample has survived DB_CYCLES consecutive cycles
   assign accept = (sample != key_level) && (db_cnt == DBW'(DB_CYCLES - 1));
   // Lets the top register any_press on the same edge as key_press
   assign press_set = accept && sample;

   // Two-flop synchroniser, idles in the released state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= key_n;
         sync2 <= sync1;
      end
   end

   // Debounce: any agreeing sample restarts the stability count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_cnt      <= '0;
         key_level   <= 1'b0;
         key_press   <= 1'b0;
         key_release <= 1'b0;
      end else begin
         key_press   <= accept && sample;
         key_release <= accept && !sample;
         if (sample == key_level) begin
            db_cnt <= '0;
         end else if (accept) begin
            db_cnt    <= '0;
            key_level <= sample;
         end else begin
            db_cnt <= db_cnt + DBW'(1);
         end
      end
   end

   // Hold timer saturates so key_hold fires only once per press
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt <= '0;
         key_hold <= 1'b0;
      end else if (!key_level) begin
         hold_cnt <= '0;
         key_hold <= 1'b0;
      end else if (hold_cnt != HW'(HOLD_CYCLES)) begin
         hold_cnt <= hold_cnt + HW'(1);
         key_hold <= (hold_cnt == HW'(HOLD_CYCLES - 1));
      end else begin
         key_hold <= 1'b0;
      end
   end

endmodule

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - conditions raw active-low pushbuttons into clean levels and pulses
module key_conditioner
   import key_conditioner_pkg::*;
#(
   parameter int NUM_KEYS    = 2,
   parameter int CLK_HZ      = CLK_HZ_DEFAULT,
   parameter int DEBOUNCE_MS = 10,
   parameter int HOLD_MS     = 1000
) (
   input  logic                MAX10_CLK1_50,
   input  logic                reset_n,
   input  logic [NUM_KEYS-1:0] key_n,
   output logic [NUM_KEYS-1:0] key_level,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release,
   output logic [NUM_KEYS-1:0] key_hold,
   output logic                any_press
);

   localparam int DB_CYCLES   = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
   localparam int HOLD_CYCLES = ms_to_cycles(CLK_HZ, HOLD_MS);

   // Reject configurations where the counters or pulse exclusivity break down
   if (DB_CYCLES < 2) begin : g_db_check
      $error("key_conditioner: DB_CYCLES must be at least 2");
   end
   if (HOLD_CYCLES <= DB_CYCLES) begin : g_hold_check
      $error("key_conditioner: HOLD_CYCLES must exceed DB_CYCLES");
   end

   logic [NUM_KEYS-1:0] press_set;

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      key_debounce_channel #(
         .DB_CYCLES   (DB_CYCLES),
         .HOLD_CYCLES (HOLD_CYCLES)
      ) u_chan (
         .clk         (MAX10_CLK1_50),
         .rst_n       (reset_n),
         .key_n       (key_n[i]),
         .key_level   (key_level[i]),
         .key_press   (key_press[i]),
         .key_release (key_release[i]),
         .key_hold    (key_hold[i]),
         .press_set   (press_set[i])
      );
   end

   // Registered OR of the press events, aligned with key_press
   always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
      if (!reset_n) begin
         any_press <= 1'b0;
      end else begin
         any_press <= |press_set;
      end
   end

endmodule
